// File: rtl/cpu_r_pkg.sv
// Shared encodings for the R-type CPU: controller states, ALU operation codes
// and the function-field constants the decoder, ALU and datapath agree on.
package cpu_r_pkg;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_IF   = 3'd1,
        ST_IFW  = 3'd2,
        ST_ID   = 3'd3,
        ST_EX   = 3'd4,
        ST_WB   = 3'd5,
        ST_ERR  = 3'd6
    } state_t;

    typedef enum logic [2:0] {
        ALU_AND = 3'd0,
        ALU_OR  = 3'd1,
        ALU_XOR = 3'd2,
        ALU_NOR = 3'd3,
        ALU_ADD = 3'd4,
        ALU_SUB = 3'd5,
        ALU_SLT = 3'd6,
        ALU_SLL = 3'd7
    } alu_op_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;

    localparam logic [5:0] FUNC_AND = 6'b100100;
    localparam logic [5:0] FUNC_OR  = 6'b100101;
    localparam logic [5:0] FUNC_XOR = 6'b100110;
    localparam logic [5:0] FUNC_NOR = 6'b100111;
    localparam logic [5:0] FUNC_ADD = 6'b100000;
    localparam logic [5:0] FUNC_SUB = 6'b100010;
    localparam logic [5:0] FUNC_SLT = 6'b101010;
    localparam logic [5:0] FUNC_SLL = 6'b000000;

    localparam int INST_CNT_W = 16;

endpackage

// File: rtl/r_func_decode.sv
// Combinational R-type decode: legality check and func-to-ALU_OP mapping.
module r_func_decode
    import cpu_r_pkg::*;
(
    input  logic [5:0] op_code,
    input  logic [5:0] func,
    output logic       legal,
    output alu_op_t    alu_op
);

    always_comb begin
        legal  = 1'b0;
        alu_op = ALU_AND;
        if (op_code == OP_RTYPE) begin
            legal = 1'b1;
            case (func)
                FUNC_AND: alu_op = ALU_AND;
                FUNC_OR:  alu_op = ALU_OR;
                FUNC_XOR: alu_op = ALU_XOR;
                FUNC_NOR: alu_op = ALU_NOR;
                FUNC_ADD: alu_op = ALU_ADD;
                FUNC_SUB: alu_op = ALU_SUB;
                FUNC_SLT: alu_op = ALU_SLT;
                FUNC_SLL: alu_op = ALU_SLL;
                default:  legal  = 1'b0;
            endcase
        end
    end

endmodule

// File: rtl/cpu_r_ctrl.sv
// Multi-cycle controller for R-type instructions: IF, IFW, ID, EX, WB with a
// sticky error trap for illegal words and a saturating retired-instruction count.
module cpu_r_ctrl
    import cpu_r_pkg::*;
(
    input  logic                  clk,
    input  logic                  Reset,
    input  logic                  run,
    input  logic [5:0]            op_code,
    input  logic [5:0]            func,
    output logic                  PC_inc,
    output logic                  IR_we,
    output logic                  RF_we,
    output logic [2:0]            ALU_OP,
    output logic [2:0]            state,
    output logic                  err,
    output logic [INST_CNT_W-1:0] inst_cnt
);

    state_t                state_q;
    state_t                state_d;
    alu_op_t               alu_op_q;
    logic                  err_q;
    logic [INST_CNT_W-1:0] inst_cnt_q;
    logic                  dec_legal;
    alu_op_t               dec_alu_op;

    function automatic logic [INST_CNT_W-1:0] sat_inc(input logic [INST_CNT_W-1:0] v);
        return (v == {INST_CNT_W{1'b1}}) ? v : v + 1'b1;
    endfunction

    r_func_decode u_decode (
        .op_code (op_code),
        .func    (func),
        .legal   (dec_legal),
        .alu_op  (dec_alu_op)
    );

    // State register and the registered side effects of each transition
    always_ff @(posedge clk) begin
        if (!Reset) begin
            state_q    <= ST_IDLE;
            alu_op_q   <= ALU_AND;
            err_q      <= 1'b0;
            inst_cnt_q <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == ST_ID && dec_legal)
                alu_op_q <= dec_alu_op;
            if (state_d == ST_ERR)
                err_q <= 1'b1;
            if (state_q == ST_WB)
                inst_cnt_q <= sat_inc(inst_cnt_q);
        end
    end

    // Next state plus Moore strobes decoded from the registered state;
    // run is only looked at in IDLE and WB so a started instruction always finishes
    always_comb begin
        state_d = state_q;
        PC_inc  = 1'b0;
        IR_we   = 1'b0;
        RF_we   = 1'b0;
        case (state_q)
            ST_IDLE: state_d = run ? ST_IF : ST_IDLE;
            ST_IF:   state_d = ST_IFW;
            ST_IFW: begin
                state_d = ST_ID;
                IR_we   = 1'b1;
            end
            ST_ID:   state_d = dec_legal ? ST_EX : ST_ERR;
            ST_EX:   state_d = ST_WB;
            ST_WB: begin
                state_d = run ? ST_IF : ST_IDLE;
                RF_we   = 1'b1;
                PC_inc  = 1'b1;
            end
            ST_ERR:  state_d = ST_ERR;
            default: state_d = ST_ERR;
        endcase
    end

    assign ALU_OP   = alu_op_q;
    assign state    = state_q;
    assign err      = err_q;
    assign inst_cnt = inst_cnt_q;

endmodule

// File: doc/cpu_r_ctrl.md
CPU_R_CTRL -- requirements
Module: cpu_r_ctrl

Interface
REQ-001 SHALL have port clk, input, 1 bit: single clock; all state changes on its rising edge.
REQ-002 SHALL have port Reset, input, 1 bit: reset that is synchronous and active-low.
REQ-003 SHALL have port run, input, 1 bit: level request to execute instructions continuously.
REQ-004 SHALL have port op_code, input, 6 bits: instruction bits [31:26] from the fetch unit.
REQ-005 SHALL have port func, input, 6 bits: instruction bits [5:0] from the fetch unit.
REQ-006 SHALL have port PC_inc, output, 1 bit: one-cycle pulse that advances the fetch PC.
REQ-007 SHALL have port IR_we, output, 1 bit: one-cycle pulse that captures the ROM output into the instruction register.
REQ-008 SHALL have port RF_we, output, 1 bit: one-cycle pulse that writes the ALU result to register rd.
REQ-009 SHALL have port ALU_OP, output, 3 bits: registered ALU operation select.
REQ-010 SHALL have port state, output, 3 bits: current FSM state, for debug.
REQ-011 SHALL have port err, output, 1 bit: sticky illegal-instruction flag.
REQ-012 SHALL have port inst_cnt, output, 16 bits: count of retired instructions.

Function
REQ-013 SHALL use states IDLE=0, IF=1, IFW=2, ID=3, EX=4, WB=5, ERR=6.
REQ-014 SHALL move IDLE->IF when run=1 and stay in IDLE otherwise.
REQ-015 SHALL move IF->IFW unconditionally, covering the one-cycle ROM read latency.
REQ-016 SHALL move IFW->ID and assert IR_we during IFW only.
REQ-017 SHALL decode in ID; legal means op_code=0 and func is in the table below; legal goes ID->EX, illegal goes ID->ERR.
REQ-018 SHALL map func to ALU_OP as: 100100 and=0, 100101 or=1, 100110 xor=2, 100111 nor=3, 100000 add=4, 100010 sub=5, 101010 slt=6, 000000 sll=7.
REQ-019 SHALL register ALU_OP on the ID->EX transition and hold it unchanged through EX and WB until the next legal decode.
REQ-020 SHALL move EX->WB unconditionally; EX gives a one-cycle ALU settle.
REQ-021 SHALL assert RF_we and PC_inc together, for exactly the one WB cycle.
REQ-022 SHALL leave WB for IF when run=1 and for IDLE when run=0.
REQ-023 SHALL sample run only in IDLE and WB; deasserting run mid-instruction completes that instruction through WB, then goes to IDLE.
REQ-024 SHALL make one instruction take 5 cycles from IF to WB inclusive, with back-to-back throughput of 1 instruction per 5 cycles.
REQ-025 SHALL increment inst_cnt by 1 in each WB cycle and saturate it at 0xFFFF with no wrap.
REQ-026 SHALL, in ERR: set err=1, hold PC_inc, IR_we and RF_we at 0, hold ALU_OP, ignore run; only Reset exits ERR.
REQ-027 SHALL never assert PC_inc for an illegal instruction; PC stays pointing at the faulting word.
REQ-028 SHALL drive PC_inc, IR_we and RF_we as decoded Moore outputs of state, glitch-free and registered-state based.
REQ-029 SHALL treat unused encoding 7 as ERR.

Reset
REQ-030 SHALL, when Reset=0 at a rising clk edge, force: state=IDLE, ALU_OP=0, err=0, inst_cnt=0, PC_inc=0, IR_we=0, RF_we=0.
REQ-031 SHALL give Reset priority over every transition, including mid-instruction and ERR; an instruction aborted before WB is not retired and does not pulse PC_inc.
REQ-032 SHALL re-enter IF after Reset releases only if run=1 in IDLE.

Structure
REQ-033 SHALL place the state encodings, the ALU_OP codes and the func constants in shared package cpu_r_pkg, which the ALU and datapath reuse.
REQ-034 SHALL put the combinational func-to-ALU_OP and legality decode in sub-module r_func_decode, instantiated once.
REQ-035 SHALL contain no arithmetic other than the inst_cnt saturating increment.

Verification
REQ-036 SHALL test: Reset=0 for 2 cycles, run=1, op=0, func=100000 -> state 1,2,3,4,5; IR_we high in cycle 2; RF_we and PC_inc high in cycle 5 only; ALU_OP=4; inst_cnt=1.
REQ-037 SHALL test: run held high over 3 instructions (sub, slt, sll) -> PC_inc pulses 5 cycles apart; ALU_OP=5, 6, 7 in turn; inst_cnt=3.
REQ-038 SHALL test: op_code=6'b100011 (lw) -> ERR within 3 cycles of IF; err=1; no PC_inc; run toggling has no effect; Reset=0 clears err to 0 and returns to IDLE.
REQ-039 SHALL test: run dropped during EX -> WB still pulses RF_we and PC_inc, then IDLE, with no further IF.
REQ-040 SHALL test: Reset=0 asserted in EX -> next cycle IDLE, RF_we=0, inst_cnt unchanged from its pre-instruction value, which after reset is 0.
REQ-041 SHALL test: inst_cnt preloaded to 0xFFFE by force, then 3 retirements -> reads 0xFFFF and holds.
